// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset PC default and the
// end-of-program marker word.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] STOP_WORD        = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch buffer holding {pc, inst} entries; clear empties it in one
// cycle and dominates push/pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full buffer is accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign full  = (count == FULL);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues in-order imem requests, buffers the
// responses with their PCs and hands them to the IF/ID register.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        stop_out
);

  localparam int unsigned CW  = $clog2(MAX_OUTST + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW:0] LIMIT = CW1'(MAX_OUTST);

  fetch_state_t  state, state_n;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic          req_q;
  logic [CW-1:0] outst, outst_n;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_cnt, cnt_n;
  logic [63:0]   head;
  logic          fifo_empty, fifo_full;
  logic          issue, xfer, stale, push, pop, clear;
  logic          head_stop, stop_xfer, room;

  assign issue     = req_q && imem_gnt;
  assign valid_out = !fifo_empty;
  assign xfer      = valid_out && id_ready;
  assign head_stop = (head[31:0] == STOP_WORD);
  assign stop_xfer = xfer && head_stop;
  assign stale     = (discard != '0);
  assign clear     = redirect_valid || stop_xfer;
  assign pop       = xfer && !clear;
  assign push      = imem_rvalid && !stale && (state != ST_HALT) && !redirect_valid
                     && (!fifo_full || pop);

  assign imem_req  = req_q;
  assign imem_addr = fetch_pc;
  assign inst_out  = head[31:0];
  assign pc_out    = head[63:32];
  assign stop_out  = valid_out && head_stop;

  fetch_fifo #(
    .DEPTH(MAX_OUTST)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .pop  (pop),
    .clear(clear),
    .wdata({resp_pc, imem_rdata}),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );

  // The request line is registered, so its next value is judged against the
  // occupancy the buffer and imem will have after this edge.
  always_comb begin
    outst_n = outst + CW'(issue) - CW'(imem_rvalid);
    cnt_n   = clear ? '0 : fifo_cnt + CW'(push) - CW'(pop);
    room    = ({1'b0, outst_n} + {1'b0, cnt_n}) < LIMIT;
    state_n = state;
    if (redirect_valid)                             state_n = ST_RUN;
    else if (stop_xfer)                             state_n = ST_HALT;
    else if (state == ST_RUN && push && imem_rdata == STOP_WORD) state_n = ST_DRAIN;
  end

  // resp_pc tracks the PC of the next live response; discard counts beats
  // still owed by requests issued before the last redirect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_RUN;
      req_q    <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      outst    <= '0;
      discard  <= '0;
    end else begin
      state <= state_n;
      outst <= outst_n;
      req_q <= (state_n == ST_RUN) && room;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        discard  <= outst_n;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        if (imem_rvalid && stale) discard <= discard - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an in-order, variable-latency imem
// model and a transfer monitor on the IF/ID side.
module tb_fetch_sequencer;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        stop_out;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int n_issue = 0;
  int req_cycles = 0;
  int ncyc = 0;

  typedef struct {int due; logic [31:0] a;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst; logic stop;} xfer_t;
  pend_t pq[$];
  xfer_t xq[$];

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .MAX_OUTST(2)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .inst_out      (inst_out),
    .pc_out        (pc_out),
    .valid_out     (valid_out),
    .stop_out      (stop_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00a0_0113;
      32'h8:   return 32'h0000_0000;
      default: return {a[23:0], 8'h13};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_xq(input int n, input int budget, input string tag);
    int i = 0;
    while (xq.size() < n && i < budget) begin
      step(1);
      i++;
    end
    chk(tag, 32'(xq.size()), 32'(n));
  endtask

  // imem: sample the cycle's request before the edge, answer in order after it
  initial begin
    logic        iss;
    logic [31:0] ia;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      iss = imem_req && imem_gnt && rstn;
      ia  = imem_addr;
      @(posedge clk);
      #2;
      ncyc++;
      if (!rstn) begin
        pq.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end else begin
        if (iss) begin
          pq.push_back('{due: ncyc + lat - 1, a: ia});
          n_issue++;
        end
        if (pq.size() > 0 && pq[0].due <= ncyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word(pq[0].a);
          void'(pq.pop_front());
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = '0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rstn && imem_req) req_cycles++;
      if (rstn && valid_out && id_ready)
        xq.push_back('{pc: pc_out, inst: inst_out, stop: stop_out});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    rstn = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    #3;
    chk("rst_req",   32'(imem_req),  0);
    chk("rst_addr",  imem_addr,      32'h0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_stop",  32'(stop_out),  0);
    chk("rst_inst",  inst_out,       32'h0);
    chk("rst_pc",    pc_out,         32'h0);

    // program 0,4,8(stop) with 1-cycle imem
    step(2);
    rstn = 1'b1;
    chk("req_before_first_clk", 32'(imem_req), 0);
    step(1);
    chk("first_req",  32'(imem_req), 1);
    chk("first_addr", imem_addr, 32'h0);
    wait_xq(3, 40, "prog_count");
    chk("prog_pc0",   xq[0].pc, 32'h0);
    chk("prog_inst0", xq[0].inst, 32'h0050_0093);
    chk("prog_stop0", 32'(xq[0].stop), 0);
    chk("prog_pc1",   xq[1].pc, 32'h4);
    chk("prog_inst1", xq[1].inst, 32'h00a0_0113);
    chk("prog_stop1", 32'(xq[1].stop), 0);
    chk("prog_pc2",   xq[2].pc, 32'h8);
    chk("prog_stop2", 32'(xq[2].stop), 1);
    base = req_cycles;
    step(10);
    chk("halt_no_req", 32'(req_cycles - base), 0);

    // redirect out of HALT to 0x40, then stall the consumer for 10 cycles
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(1);
    redirect_valid = 1'b0; id_ready = 1'b0;
    chk("halt_redir_req",   32'(imem_req), 1);
    chk("halt_redir_addr",  imem_addr, 32'h40);
    chk("halt_redir_valid", 32'(valid_out), 0);
    base = n_issue; bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (i >= 2 && (valid_out !== 1'b1 || pc_out !== 32'h40 || inst_out !== 32'h0000_4013 || stop_out !== 1'b0))
        bad++;
    end
    chk("stall_hold",   32'(bad), 0);
    chk("stall_issues", 32'(n_issue - base), 2);
    xq.delete();
    id_ready = 1'b1;
    wait_xq(4, 40, "resume_count");
    for (int i = 0; i < 4; i++) begin
      chk("resume_pc",   xq[i].pc,   32'h40 + 32'(4 * i));
      chk("resume_inst", xq[i].inst, word(32'h40 + 32'(4 * i)));
    end

    // grant withheld for 3 cycles after a redirect to 0x4
    redirect_valid = 1'b1; redirect_pc = 32'h4; imem_gnt = 1'b0;
    step(1);
    redirect_valid = 1'b0;
    xq.delete();
    chk("gnt_req",   32'(imem_req), 1);
    chk("gnt_addr",  imem_addr, 32'h4);
    chk("gnt_valid", 32'(valid_out), 0);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      if (imem_req !== 1'b1 || imem_addr !== 32'h4) bad++;
    end
    chk("gnt_hold", 32'(bad), 0);
    imem_gnt = 1'b1;
    step(1);
    chk("gnt_next_addr", imem_addr, 32'h8);
    wait_xq(2, 40, "gnt_count");
    chk("gnt_pc0",   xq[0].pc, 32'h4);
    chk("gnt_inst0", xq[0].inst, 32'h00a0_0113);
    chk("gnt_pc1",   xq[1].pc, 32'h8);
    chk("gnt_stop1", 32'(xq[1].stop), 1);
    step(3);

    // redirect to 0x100 with two 3-cycle requests in flight
    lat = 3;
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step(1);
    redirect_valid = 1'b0;
    base = n_issue;
    step(2);
    chk("inflight_req",  32'(imem_req), 0);
    chk("inflight_addr", imem_addr, 32'h88);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step(1);
    redirect_valid = 1'b0;
    xq.delete();
    chk("inflight_issues", 32'(n_issue - base), 2);
    chk("redir_valid_low", 32'(valid_out), 0);
    wait_xq(1, 40, "redir_count");
    chk("redir_pc",   xq[0].pc, 32'h100);
    chk("redir_inst", xq[0].inst, 32'h0001_0013);

    // reset with a full buffer
    id_ready = 1'b0;
    step(12);
    chk("full_valid", 32'(valid_out), 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_req",   32'(imem_req), 0);
    chk("mid_rst_addr",  imem_addr, 32'h0);
    chk("mid_rst_valid", 32'(valid_out), 0);
    chk("mid_rst_stop",  32'(stop_out), 0);
    chk("mid_rst_inst",  inst_out, 32'h0);
    chk("mid_rst_pc",    pc_out, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3;
    lat = 1; id_ready = 1'b1; rstn = 1'b1;
    xq.delete();
    wait_xq(3, 40, "restart_count");
    chk("restart_pc0",   xq[0].pc, 32'h0);
    chk("restart_inst0", xq[0].inst, 32'h0050_0093);
    chk("restart_pc1",   xq[1].pc, 32'h4);
    chk("restart_pc2",   xq[2].pc, 32'h8);
    chk("restart_stop2", 32'(xq[2].stop), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
